imem_program_loader: RTL and testbench

Hardware program loader that writes the instruction memory of cpu_pipelined from a valid/ready word stream, replacing back-door memory preloading. While loading, the loader holds the CPU in reset. It zero-fills the rest of the memory and then releases the CPU. It watches end_program, reports the halt, and can reload on a new start pulse. It sits between a host/UART-side stream source and the imem write port.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/imem_program_loader.sv | 156 +++++++++++++++
 tb/tb_imem_program_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_pipelined slice: instruction width,
// the fill/end-marker word and the program-loader state encoding.
package cpu_pkg;

  localparam int INSTR_WIDTH = 32;

  // All-zero word doubles as NOP-fill and end-of-program marker
  localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [2:0] {
    LD_IDLE   = 3'd0,
    LD_LOAD   = 3'd1,
    LD_FILL   = 3'd2,
    LD_DRAIN  = 3'd3,
    LD_RUN    = 3'd4,
    LD_HALTED = 3'd5
  } loader_state_e;

endpackage

// File: rtl/imem_program_loader.sv
// Streams a program into the CPU instruction memory, zero-fills the rest,
// then releases the CPU from reset and watches for its halt.
//
// state     | meaning
// LD_IDLE   | CPU held in reset, waiting for start
// LD_LOAD   | accepting stream words, one imem write per handshake
// LD_FILL   | writing the fill word up to the top address
// LD_DRAIN  | program too long; discarding words up to s_last
// LD_RUN    | memory complete, CPU released
// LD_HALTED | CPU reported end_program, still released
module imem_program_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = INSTR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0] imem_wdata,
  output logic                  cpu_reset,
  input  logic                  end_program,
  output logic                  load_done,
  output logic                  halted,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

  loader_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]     word_count_q, word_count_d;
  logic                    s_ready_q, s_ready_d;
  logic                    imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
  logic [DATA_WIDTH-1:0]   imem_wdata_q, imem_wdata_d;
  logic                    cpu_reset_q, cpu_reset_d;
  logic                    load_done_q, load_done_d;
  logic                    halted_q, halted_d;
  logic                    overflow_q, overflow_d;
  logic                    handshake;
  logic                    restart;

  assign handshake = s_valid & s_ready_q;
  assign restart   = start & ((state_q == LD_IDLE) | (state_q == LD_RUN) |
                              (state_q == LD_HALTED));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= LD_IDLE;
      ptr_q        <= '0;
      word_count_q <= '0;
      s_ready_q    <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      cpu_reset_q  <= 1'b1;
      load_done_q  <= 1'b0;
      halted_q     <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      word_count_q <= word_count_d;
      s_ready_q    <= s_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      cpu_reset_q  <= cpu_reset_d;
      load_done_q  <= load_done_d;
      halted_q     <= halted_d;
      overflow_q   <= overflow_d;
    end
  end

  // cpu_reset/load_done follow state_q rather than state_d, so release lands
  // one cycle after the final write that moved the FSM into LD_RUN.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    word_count_d = word_count_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    cpu_reset_d  = 1'b1;
    load_done_d  = 1'b0;
    halted_d     = halted_q;
    overflow_d   = overflow_q;

    if (restart) begin
      state_d      = LD_LOAD;
      ptr_d        = '0;
      word_count_d = '0;
      overflow_d   = 1'b0;
      halted_d     = 1'b0;
    end else begin
      case (state_q)
        LD_IDLE: ;
        LD_LOAD: begin
          if (handshake) begin
            imem_we_d    = 1'b1;
            imem_addr_d  = ptr_q;
            imem_wdata_d = s_data;
            ptr_d        = ptr_q + 1'b1;
            word_count_d = word_count_q + 1'b1;
            if (s_last) begin
              state_d = (ptr_q == LAST_ADDR) ? LD_RUN : LD_FILL;
            end else if (ptr_q == LAST_ADDR) begin
              overflow_d = 1'b1;
              state_d    = LD_DRAIN;
            end
          end
        end
        LD_FILL: begin
          imem_we_d    = 1'b1;
          imem_addr_d  = ptr_q;
          imem_wdata_d = DATA_WIDTH'(NOP_INSTR);
          ptr_d        = ptr_q + 1'b1;
          if (ptr_q == LAST_ADDR) state_d = LD_RUN;
        end
        LD_DRAIN: begin
          if (handshake && s_last) state_d = LD_IDLE;
        end
        LD_RUN, LD_HALTED: begin
          cpu_reset_d = 1'b0;
          load_done_d = 1'b1;
          if ((state_q == LD_RUN) && end_program) begin
            state_d  = LD_HALTED;
            halted_d = 1'b1;
          end
        end
        default: state_d = LD_IDLE;
      endcase
    end

    s_ready_d = (state_d == LD_LOAD) || (state_d == LD_DRAIN);
  end

  assign s_ready    = s_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign load_done  = load_done_q;
  assign halted     = halted_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: a 64-word instance for the main
// program/halt/reset scenarios and an 8-word instance for the depth limits.
module tb_imem_program_loader;

  typedef struct {
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_err;

  // 64-word instance
  logic        start6, s_valid6, s_last6, end_program6;
  logic [31:0] s_data6;
  logic        s_ready6, imem_we6, cpu_reset6, load_done6, halted6, overflow6;
  logic [5:0]  imem_addr6;
  logic [31:0] imem_wdata6;
  logic [6:0]  word_count6;

  // 8-word instance
  logic        start3, s_valid3, s_last3, end_program3;
  logic [31:0] s_data3;
  logic        s_ready3, imem_we3, cpu_reset3, load_done3, halted3, overflow3;
  logic [2:0]  imem_addr3;
  logic [31:0] imem_wdata3;
  logic [3:0]  word_count3;

  logic [31:0] prog [0:5];

  wr_t log6[$];
  wr_t log3[$];
  int  hs6[$];
  int  hs3[$];
  int  rel6, rel3, ovf3;
  logic prev_crst6, prev_crst3, prev_ovf3;

  imem_program_loader #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) u_dut6 (
    .clk(clk), .reset(reset), .start(start6),
    .s_valid(s_valid6), .s_ready(s_ready6), .s_data(s_data6), .s_last(s_last6),
    .imem_we(imem_we6), .imem_addr(imem_addr6), .imem_wdata(imem_wdata6),
    .cpu_reset(cpu_reset6), .end_program(end_program6), .load_done(load_done6),
    .halted(halted6), .overflow(overflow6), .word_count(word_count6)
  );

  imem_program_loader #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3),
    .s_valid(s_valid3), .s_ready(s_ready3), .s_data(s_data3), .s_last(s_last3),
    .imem_we(imem_we3), .imem_addr(imem_addr3), .imem_wdata(imem_wdata3),
    .cpu_reset(cpu_reset3), .end_program(end_program3), .load_done(load_done3),
    .halted(halted3), .overflow(overflow3), .word_count(word_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write log and event timestamps, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_we6) log6.push_back('{int'(imem_addr6), imem_wdata6, cyc});
    if (imem_we3) log3.push_back('{int'(imem_addr3), imem_wdata3, cyc});
    if (!cpu_reset6 && prev_crst6) rel6 <= cyc;
    if (!cpu_reset3 && prev_crst3) rel3 <= cyc;
    if (overflow3 && !prev_ovf3) ovf3 <= cyc;
    prev_crst6 <= cpu_reset6;
    prev_crst3 <= cpu_reset3;
    prev_ovf3  <= overflow3;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    if (i < 6) return prog[i];
    return 32'hA000_0000 + 32'(i);
  endfunction

  task automatic set_stream(input bit sel, input logic v, input logic [31:0] d, input logic l);
    if (sel) begin
      s_valid3 = v; s_data3 = d; s_last3 = l;
    end else begin
      s_valid6 = v; s_data6 = d; s_last6 = l;
    end
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) begin
      log3.delete(); hs3.delete(); rel3 = -1; ovf3 = -1; start3 = 1'b1;
    end else begin
      log6.delete(); hs6.delete(); rel6 = -1; start6 = 1'b1;
    end
    @(negedge clk);
    start3 = 1'b0;
    start6 = 1'b0;
  endtask

  task automatic stream(input bit sel, input int n, input bit gaps, input bit with_last);
    int budget;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (gaps && i > 0) begin
        set_stream(sel, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
      end
      set_stream(sel, 1'b1, word(i), with_last && (i == n - 1));
      budget = 0;
      while (!(sel ? s_ready3 : s_ready6) && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (budget >= 20) check("stream_ready_timeout", 0, 1);
      if (sel) hs3.push_back(cyc + 1);
      else     hs6.push_back(cyc + 1);
    end
    @(negedge clk);
    set_stream(sel, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic wait_done(input bit sel);
    int budget;
    budget = 0;
    while (!(sel ? load_done3 : load_done6) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 200) check("load_done_timeout", 0, 1);
    @(negedge clk);
  endtask

  // Expected image: stream words first, then zero fill, each write one
  // cycle after its handshake
  task automatic check_image(input bit sel, input int n_prog, input int exp_total);
    wr_t lg[$];
    int  hs[$];
    lg = sel ? log3 : log6;
    hs = sel ? hs3 : hs6;
    check("write_count", lg.size(), exp_total);
    for (int i = 0; i < lg.size() && i < exp_total; i++) begin
      check($sformatf("wr_addr[%0d]", i), lg[i].addr, i);
      check($sformatf("wr_data[%0d]", i), lg[i].data, (i < n_prog) ? word(i) : 32'h0);
      if (i < n_prog && i < hs.size())
        check($sformatf("wr_latency[%0d]", i), lg[i].cyc, hs[i]);
    end
  endtask

  initial begin
    prog[0] = 32'h0030_0093; prog[1] = 32'h0070_0113; prog[2] = 32'h0000_8863;
    prog[3] = 32'h0011_0133; prog[4] = 32'hFFF0_8093; prog[5] = 32'hFE00_0AE3;
    n_checks = 0; n_err = 0; cyc = 0;
    rel6 = -1; rel3 = -1; ovf3 = -1;
    start6 = 0; s_valid6 = 0; s_data6 = 0; s_last6 = 0; end_program6 = 0;
    start3 = 0; s_valid3 = 0; s_data3 = 0; s_last3 = 0; end_program3 = 0;
    reset = 1'b0;
    #23;
    check("rst_cpu_reset", cpu_reset6, 1);
    check("rst_s_ready",   s_ready6,   0);
    check("rst_imem_we",   imem_we6,   0);
    check("rst_imem_addr", imem_addr6, 0);
    check("rst_wdata",     imem_wdata6, 0);
    check("rst_load_done", load_done6, 0);
    check("rst_halted",    halted6,    0);
    check("rst_overflow",  overflow6,  0);
    check("rst_word_count", word_count6, 0);
    check("rst3_cpu_reset", cpu_reset3, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_ready", s_ready6, 0);

    // Six-word program, s_valid held high
    pulse_start(0);
    check("load_s_ready", s_ready6, 1);
    stream(0, 6, 0, 1);
    wait_done(0);
    check_image(0, 6, 64);
    check("s1_release_cycle", rel6, log6[log6.size()-1].cyc + 1);
    check("s1_word_count", word_count6, 6);
    check("s1_load_done", load_done6, 1);
    check("s1_cpu_reset", cpu_reset6, 0);
    check("s1_overflow", overflow6, 0);

    // Halt then restart
    @(negedge clk);
    end_program6 = 1'b1;
    @(negedge clk);
    end_program6 = 1'b0;
    check("halt_halted", halted6, 1);
    check("halt_cpu_reset", cpu_reset6, 0);
    check("halt_load_done", load_done6, 1);
    log6.delete(); hs6.delete(); rel6 = -1;
    start6 = 1'b1;
    @(negedge clk);
    start6 = 1'b0;
    check("restart_cpu_reset", cpu_reset6, 1);
    check("restart_halted", halted6, 0);
    check("restart_load_done", load_done6, 0);
    check("restart_s_ready", s_ready6, 1);
    check("restart_word_count", word_count6, 0);

    // Same program, s_valid toggling
    stream(0, 6, 1, 1);
    wait_done(0);
    check_image(0, 6, 64);
    check("s2_release_cycle", rel6, log6[log6.size()-1].cyc + 1);
    check("s2_word_count", word_count6, 6);

    // Depth 8, ten words: overflow and drain
    pulse_start(1);
    stream(1, 10, 0, 1);
    repeat (4) @(negedge clk);
    check_image(1, 10, 8);
    check("ovf_flag", overflow3, 1);
    check("ovf_cycle", ovf3, hs3[7]);
    check("ovf_word_count", word_count3, 8);
    check("ovf_cpu_reset", cpu_reset3, 1);
    check("ovf_load_done", load_done3, 0);
    check("ovf_idle_ready", s_ready3, 0);

    // Depth 8, exactly eight words: no fill
    pulse_start(1);
    check("exact_ovf_cleared", overflow3, 0);
    stream(1, 8, 0, 1);
    wait_done(1);
    repeat (3) @(negedge clk);
    check_image(1, 8, 8);
    check("exact_release_cycle", rel3, log3[log3.size()-1].cyc + 1);
    check("exact_overflow", overflow3, 0);
    check("exact_word_count", word_count3, 8);
    check("exact_load_done", load_done3, 1);

    // Reset asserted mid-stream after three words
    pulse_start(0);
    stream(0, 3, 0, 0);
    check("mid_word_count", word_count6, 3);
    s_valid6 = 1'b1;
    s_data6  = 32'hDEAD_BEEF;
    reset    = 1'b0;
    #1;
    check("abort_cpu_reset", cpu_reset6, 1);
    check("abort_s_ready", s_ready6, 0);
    check("abort_imem_we", imem_we6, 0);
    check("abort_imem_addr", imem_addr6, 0);
    check("abort_wdata", imem_wdata6, 0);
    check("abort_word_count", word_count6, 0);
    check("abort_load_done", load_done6, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_writes", log6.size(), 3);
    check("abort_idle_ready", s_ready6, 0);
    s_valid6 = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
